// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART FIFO transceiver.
package uart_pkg;

    localparam int DEFAULT_BAUD_DIV = 868;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // One extra bit distinguishes full from empty.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO. A push into a full FIFO is accepted when a pop
// happens in the same cycle.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              push,
    input  logic [WIDTH-1:0]                  push_data,
    input  logic                              pop,
    output logic [WIDTH-1:0]                  pop_data,
    output logic                              full,
    output logic                              empty,
    output logic [fifo_ptr_width(DEPTH)-1:0]  count
);
    localparam int PW = fifo_ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        empty    = (count == '0);
        full     = (count == PW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        pop_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_fifo_xcvr.sv
// Full-duplex UART with RX/TX FIFOs, sticky errors and runtime echo.
// Optional parity bit (both directions) enabled by defining UART_PARITY_EN.
module uart_fifo_xcvr
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    input  logic                 echo_en,
    input  logic                 err_clr,
`ifdef UART_PARITY_EN
    input  logic                 parity_odd,
`endif
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 parity_err,
    output logic                 rx_busy,
    output logic                 tx_busy
);
    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam int PW = fifo_ptr_width(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_C = CW'(BAUD_DIV);
    localparam logic [CW-1:0] HALF_C = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    logic par_odd;
    assign par_odd = parity_odd;
`else
    localparam bit PARITY_EN = 1'b0;
    logic par_odd;
    assign par_odd = 1'b0;
`endif

    logic sync1_q, sync1_d, sync2_q, sync2_d;
    rx_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0] rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    tx_state_t tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic tx_par_q, tx_par_d, tx_out_q, tx_out_d;
    logic frame_err_q, frame_err_d, overrun_err_q, overrun_err_d, parity_err_q, parity_err_d;

    logic rx_sync, rx_tick, tx_tick, rx_commit, frame_set, parity_set;
    logic rx_full, rx_empty, tx_full, tx_empty, tx_push, tx_pop, rx_pop, rx_drop, tx_drop;
    logic [DATA_BITS-1:0] tx_head, tx_push_data;
    logic [PW-1:0] rx_count_unused, tx_count_unused;

    assign rx_sync = sync2_q;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_commit), .push_data(rx_shift_q),
        .pop(rx_pop), .pop_data(rx_data), .full(rx_full), .empty(rx_empty),
        .count(rx_count_unused)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .push_data(tx_push_data),
        .pop(tx_pop), .pop_data(tx_head), .full(tx_full), .empty(tx_empty),
        .count(tx_count_unused)
    );

    always_comb begin
        sync1_d = uart_rx;
        sync2_d = sync1_q;
        rx_pop       = rx_ready && !rx_empty;
        tx_ready     = !tx_full && !echo_en;
        tx_push      = echo_en ? rx_commit : (tx_valid && tx_ready);
        tx_push_data = echo_en ? rx_shift_q : tx_data;
        // A full FIFO still takes a byte when the head leaves in the same cycle.
        rx_drop = rx_commit && rx_full && !rx_ready;
        tx_drop = echo_en && rx_commit && tx_full && !tx_pop;
        frame_err_d   = err_clr ? 1'b0 : (frame_err_q | frame_set);
        overrun_err_d = err_clr ? 1'b0 : (overrun_err_q | rx_drop | tx_drop);
        parity_err_d  = err_clr ? 1'b0 : (parity_err_q | parity_set);
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_commit  = 1'b0;
        frame_set  = 1'b0;
        parity_set = 1'b0;
        rx_tick    = (rx_cnt_q == ONE_C);
        if (rx_state_q != RX_IDLE && !rx_tick) rx_cnt_d = rx_cnt_q - ONE_C;
        case (rx_state_q)
            RX_IDLE: if (!rx_sync) begin
                rx_state_d = RX_START;
                rx_cnt_d   = HALF_C;
            end
            RX_START: if (rx_tick) begin
                rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                rx_cnt_d   = BAUD_C;
                rx_bit_d   = '0;
            end
            RX_DATA: if (rx_tick) begin
                rx_shift_d = {rx_sync, rx_shift_q[DATA_BITS-1:1]};
                rx_cnt_d   = BAUD_C;
                rx_bit_d   = rx_bit_q + 4'd1;
                if (rx_bit_q == 4'(DATA_BITS - 1))
                    rx_state_d = PARITY_EN ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (rx_tick) begin
                parity_set = (rx_sync != ((^rx_shift_q) ^ par_odd));
                rx_state_d = RX_STOP;
                rx_cnt_d   = BAUD_C;
            end
            RX_STOP: if (rx_tick) begin
                rx_state_d = RX_IDLE;
                rx_commit  = rx_sync;
                frame_set  = !rx_sync;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_out_d   = 1'b1;
        tx_tick    = (tx_cnt_q == ONE_C);
        if (tx_state_q != TX_IDLE && !tx_tick) tx_cnt_d = tx_cnt_q - ONE_C;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_par_d   = (^tx_head) ^ par_odd;
                tx_state_d = TX_START;
                tx_cnt_d   = BAUD_C;
            end
            TX_START: begin
                tx_out_d = 1'b0;
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = BAUD_C;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                tx_out_d = tx_shift_q[0];
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_cnt_d   = BAUD_C;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                        tx_state_d = PARITY_EN ? TX_PARITY : TX_STOP;
                        tx_bit_d   = '0;
                    end
                end
            end
            TX_PARITY: begin
                tx_out_d = tx_par_q;
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    tx_cnt_d   = BAUD_C;
                end
            end
            TX_STOP: if (tx_tick) begin
                tx_cnt_d = BAUD_C;
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'(STOP_BITS - 1)) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_par_d   = (^tx_head) ^ par_odd;
                        tx_state_d = TX_START;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            tx_state_q    <= TX_IDLE;
            tx_cnt_q      <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_out_q      <= 1'b1;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            tx_state_q    <= tx_state_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_bit_q      <= tx_bit_d;
            tx_shift_q    <= tx_shift_d;
            tx_par_q      <= tx_par_d;
            tx_out_q      <= tx_out_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign uart_tx     = tx_out_q;
    assign rx_valid    = !rx_empty;
    assign rx_busy     = (rx_state_q != RX_IDLE);
    assign tx_busy     = (tx_state_q != TX_IDLE);
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
    assign parity_err  = PARITY_EN ? parity_err_q : 1'b0;

endmodule
